lcd_timing_gen: RTL and testbench

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

---
 rtl/video_types.sv | 33 +++
 rtl/stat_irq_gen.sv | 33 +++
 rtl/lcd_timing_gen.sv | 88 ++++++++
 tb/tb_lcd_timing_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/video_types.sv
// Shared video timing constants and the STAT mode encoding for the LCD pipeline.
package video_types;
  localparam int LCD_DOTS_PER_LINE = 456;
  localparam int LCD_OAM_DOTS      = 80;
  localparam int LCD_XFER_DOTS     = 172;
  localparam int LCD_VISIBLE_LINES = 144;
  localparam int LCD_TOTAL_LINES   = 154;

  localparam int DOT_W  = 9;
  localparam int LY_W   = 8;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    HBLANK = 2'd0,
    VBLANK = 2'd1,
    OAM    = 2'd2,
    XFER   = 2'd3
  } lcd_mode_t;

  // Mode of a (line, dot) position given the visible/OAM/transfer boundaries.
  function automatic lcd_mode_t mode_decode(
    input logic [LY_W-1:0]  ly,
    input logic [DOT_W-1:0] dot,
    input logic [LY_W-1:0]  vis_lines,
    input logic [DOT_W-1:0] oam_end,
    input logic [DOT_W-1:0] xfer_end
  );
    if (ly >= vis_lines)     return VBLANK;
    else if (dot < oam_end)  return OAM;
    else if (dot < xfer_end) return XFER;
    else                     return HBLANK;
  endfunction
endpackage

// File: rtl/stat_irq_gen.sv
// STAT interrupt source: OR of the selected conditions, registered history and rising-edge pulse.
module stat_irq_gen
  import video_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  lcd_mode_t  mode_nx,
  input  logic       coin_nx,
  input  logic [3:0] stat_sel,
  output logic       stat_irq
);
  logic src;
  logic src_q;

  // Evaluated on the next-cycle mode/coincidence so the pulse lines up with the new state.
  always_comb begin
    src = ((mode_nx == HBLANK) && stat_sel[0]) ||
          ((mode_nx == VBLANK) && stat_sel[1]) ||
          ((mode_nx == OAM)    && stat_sel[2]) ||
          (coin_nx             && stat_sel[3]);
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      src_q    <= 1'b0;
      stat_irq <= 1'b0;
    end else begin
      src_q    <= src;
      stat_irq <= src && !src_q;
    end
  end
endmodule

// File: rtl/lcd_timing_gen.sv
// LCD dot/line counters, STAT mode decode and the renderer/interrupt strobes.
module lcd_timing_gen
  import video_types::*;
#(
  parameter int DOTS_PER_LINE = LCD_DOTS_PER_LINE,
  parameter int OAM_DOTS      = LCD_OAM_DOTS,
  parameter int XFER_DOTS     = LCD_XFER_DOTS,
  parameter int VISIBLE_LINES = LCD_VISIBLE_LINES,
  parameter int TOTAL_LINES   = LCD_TOTAL_LINES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lcd_enable,
  input  logic [LY_W-1:0]   lyc,
  input  logic [3:0]        stat_sel,
  output logic [LY_W-1:0]   ly,
  output logic [DOT_W-1:0]  dot,
  output logic [MODE_W-1:0] mode,
  output logic              coincidence,
  output logic              drawline,
  output logic              vblank_irq,
  output logic              stat_irq,
  output logic              frame_start
);
  localparam logic [DOT_W-1:0] DOT_LAST = DOT_W'(DOTS_PER_LINE - 1);
  localparam logic [LY_W-1:0]  LY_LAST  = LY_W'(TOTAL_LINES - 1);
  localparam logic [LY_W-1:0]  VIS_LY   = LY_W'(VISIBLE_LINES);
  localparam logic [DOT_W-1:0] OAM_END  = DOT_W'(OAM_DOTS);
  localparam logic [DOT_W-1:0] XFER_END = DOT_W'(OAM_DOTS + XFER_DOTS);

  // running is low on the first enabled edge so counting restarts at (0,0).
  logic              running;
  logic              active;
  logic [DOT_W-1:0]  dot_nx;
  logic [LY_W-1:0]   ly_nx;
  lcd_mode_t         mode_nx;
  logic              coin_nx;

  assign active = lcd_enable && !reset;

  always_comb begin
    dot_nx = '0;
    ly_nx  = '0;
    if (running) begin
      if (dot == DOT_LAST) begin
        dot_nx = '0;
        ly_nx  = (ly == LY_LAST) ? '0 : ly + LY_W'(1);
      end else begin
        dot_nx = dot + DOT_W'(1);
        ly_nx  = ly;
      end
    end
    mode_nx = mode_decode(ly_nx, dot_nx, VIS_LY, OAM_END, XFER_END);
    coin_nx = (ly_nx == lyc);
  end

  always_ff @(posedge clk) begin
    if (!active) begin
      running     <= 1'b0;
      ly          <= '0;
      dot         <= '0;
      mode        <= HBLANK;
      coincidence <= 1'b0;
      drawline    <= 1'b0;
      vblank_irq  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      running     <= 1'b1;
      ly          <= ly_nx;
      dot         <= dot_nx;
      mode        <= mode_nx;
      coincidence <= coin_nx;
      drawline    <= (ly_nx < VIS_LY) && (dot_nx == OAM_END);
      vblank_irq  <= (ly_nx == VIS_LY) && (dot_nx == '0);
      frame_start <= (ly_nx == '0) && (dot_nx == '0);
    end
  end

  stat_irq_gen u_stat (
    .clk      (clk),
    .reset    (reset),
    .enable   (lcd_enable),
    .mode_nx  (mode_nx),
    .coin_nx  (coin_nx),
    .stat_sel (stat_sel),
    .stat_irq (stat_irq)
  );
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: table vectors, directed frame sequences and random stimulus vs a timeline model.
module tb_lcd_timing_gen;
  localparam int D     = 456;
  localparam int OAMD  = 80;
  localparam int XFERD = 172;
  localparam int VIS   = 144;
  localparam int TOT   = 154;
  localparam int FRAME = D * TOT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_enable = 1'b0;
  logic [7:0] lyc = 8'd0;
  logic [3:0] stat_sel = 4'd0;
  logic [7:0] ly;
  logic [8:0] dot;
  logic [1:0] mode;
  logic       coincidence, drawline, vblank_irq, stat_irq, frame_start;

  lcd_timing_gen dut (
    .clk(clk), .reset(reset), .lcd_enable(lcd_enable), .lyc(lyc), .stat_sel(stat_sel),
    .ly(ly), .dot(dot), .mode(mode), .coincidence(coincidence), .drawline(drawline),
    .vblank_irq(vblank_irq), .stat_irq(stat_irq), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int m_t = -1;
  logic m_src = 1'b0;

  function automatic logic [23:0] pk(input logic [7:0] l, input logic [8:0] d, input logic [1:0] m,
                                     input logic c, input logic dl, input logic vb, input logic st,
                                     input logic fs);
    return {l, d, m, c, dl, vb, st, fs};
  endfunction

  function automatic logic [23:0] outs();
    return pk(ly, dot, mode, coincidence, drawline, vblank_irq, stat_irq, frame_start);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (ly=%0d dot=%0d t=%0t)", name, got, exp, ly, dot, $time);
  endtask

  // Model: position is just elapsed enabled cycles folded into the frame.
  task automatic step();
    int tl, ly_e, dot_e, mode_e;
    logic src;
    logic [23:0] e;
    @(posedge clk);
    if (reset || !lcd_enable) begin
      m_t = -1; m_src = 1'b0; e = '0;
    end else begin
      m_t++;
      tl = m_t % FRAME; ly_e = tl / D; dot_e = tl % D;
      mode_e = (ly_e >= VIS) ? 1 : (dot_e < OAMD) ? 2 : (dot_e < OAMD + XFERD) ? 3 : 0;
      src = (mode_e == 0 && stat_sel[0]) || (mode_e == 1 && stat_sel[1]) ||
            (mode_e == 2 && stat_sel[2]) || (ly_e == int'(lyc) && stat_sel[3]);
      e = pk(8'(ly_e), 9'(dot_e), 2'(mode_e), ly_e == int'(lyc), ly_e < VIS && dot_e == OAMD,
             ly_e == VIS && dot_e == 0, src && !m_src, tl == 0);
      m_src = src;
    end
    #1;
    check("cycle", {8'd0, outs()}, {8'd0, e});
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  lyc;
    logic [3:0]  sel;
    logic [23:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[11];
    int frames, cnt, draws, bad_draw, lyc_irqs, coin_cyc, n143, dot143, vb_stat, vbl_n, mode1_cyc, guard;
    logic [16:0] lyc_pos, vbl_pos;
    logic switched, done;

    tbl[0]  = '{1'b1, 1'b1, 8'd0, 4'h0, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 1'b0, 8'd0, 4'h0, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b0, 1'b1, 8'd0, 4'h4, pk(0, 0, 2, 1, 0, 0, 1, 1)};
    tbl[3]  = '{1'b0, 1'b1, 8'd0, 4'h4, pk(0, 1, 2, 1, 0, 0, 0, 0)};
    tbl[4]  = '{1'b0, 1'b1, 8'd0, 4'h8, pk(0, 2, 2, 1, 0, 0, 0, 0)};
    tbl[5]  = '{1'b0, 1'b0, 8'd0, 4'h8, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{1'b0, 1'b1, 8'd5, 4'h0, pk(0, 0, 2, 0, 0, 0, 0, 1)};
    tbl[7]  = '{1'b0, 1'b1, 8'd5, 4'h4, pk(0, 1, 2, 0, 0, 0, 1, 0)};
    tbl[8]  = '{1'b1, 1'b1, 8'd5, 4'h4, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{1'b1, 1'b0, 8'd5, 4'h4, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{1'b0, 1'b1, 8'd0, 4'h0, pk(0, 0, 2, 1, 0, 0, 0, 1)};

    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst; lcd_enable = tbl[i].en; lyc = tbl[i].lyc; stat_sel = tbl[i].sel;
      step();
      check($sformatf("vec%0d", i), {8'd0, outs()}, {8'd0, tbl[i].exp});
    end

    // Free run: one full frame plus the wrap into the next.
    reset = 1'b0; lcd_enable = 1'b0; step();
    lyc = 8'd10; stat_sel = 4'b1000; lcd_enable = 1'b1;
    frames = 0; cnt = 0; draws = 0; bad_draw = 0; lyc_irqs = 0; coin_cyc = 0; n143 = 0; dot143 = -1;
    vb_stat = 0; vbl_n = 0; mode1_cyc = 0; lyc_pos = '1; vbl_pos = '1; switched = 1'b0; done = 1'b0;
    for (int c = 0; c < FRAME + 1000 && !done; c++) begin
      step();
      cnt++;
      if (frame_start) begin
        if (frames == 1) begin
          check("frame_len", cnt - 1, FRAME);
          check("draws_per_frame", draws, VIS);
        end
        frames++; cnt = 1; draws = 0;
      end
      if (frames == 1) begin
        if (drawline) begin
          draws++;
          if (dot != 9'd80 || ly >= 8'd144) bad_draw++;
        end
        if (coincidence) coin_cyc++;
        if (stat_irq && !switched) begin lyc_irqs++; lyc_pos = {ly, dot}; end
        if (stat_irq && ly == 8'd143) begin n143++; dot143 = int'(dot); end
        if (stat_irq && ly >= 8'd144) vb_stat++;
        if (vblank_irq) begin vbl_n++; vbl_pos = {ly, dot}; end
        if (ly >= 8'd144 && mode == 2'd1) mode1_cyc++;
        if (!switched && ly == 8'd20 && dot == 9'd300) begin stat_sel = 4'b0011; switched = 1'b1; end
      end
      if (frames == 2 && ly == 8'd1 && dot == 9'd200) done = 1'b1;
    end
    check("run_reached_l1_d200", {31'd0, done}, 32'd1);
    check("bad_drawline_pos", bad_draw, 0);
    check("lyc_irq_count", lyc_irqs, 1);
    check("lyc_irq_pos", {15'd0, lyc_pos}, {15'd0, 8'd10, 9'd0});
    check("coin_cycles", coin_cyc, D);
    check("hblank143_irqs", n143, 1);
    check("hblank143_dot", dot143, OAMD + XFERD);
    check("vblank_stat_irqs", vb_stat, 0);
    check("vblank_irq_count", vbl_n, 1);
    check("vblank_irq_pos", {15'd0, vbl_pos}, {15'd0, 8'd144, 9'd0});
    check("mode1_cycles", mode1_cyc, D * (TOT - VIS));

    // Mid-line disable, then re-enable.
    lcd_enable = 1'b0; step();
    check("disable_state", {8'd0, outs()}, 32'd0);
    step();
    check("disabled_hold", {8'd0, outs()}, 32'd0);
    lcd_enable = 1'b1; step();
    check("reenable_state", {8'd0, outs()}, {8'd0, pk(0, 0, 2, 0, 0, 0, 0, 1)});

    // Reset mid-line with enable held high.
    guard = 0;
    while (!(ly == 8'd3 && dot == 9'd100) && guard < 4 * D) begin step(); guard++; end
    check("run_reached_l3_d100", {31'd0, (ly == 8'd3 && dot == 9'd100)}, 32'd1);
    reset = 1'b1; step();
    check("reset_state", {8'd0, outs()}, 32'd0);
    reset = 1'b0; step();
    check("post_reset_state", {8'd0, outs()}, {8'd0, pk(0, 0, 2, 0, 0, 0, 0, 1)});

    // Random enable/reset/lyc/select activity, checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom);
      reset = ((r % 251) == 0);
      if ((r % 173) == 1) lcd_enable = ~lcd_enable;
      if ((r % 37) == 2) lyc = 8'($urandom_range(0, 2));
      if ((r % 29) == 3) stat_sel = 4'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
